// File: rtl/maze_pkg.sv
// Shared encodings and helpers for the maze game controller.
package maze_pkg;

  localparam logic [1:0] ST_WELCOME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_WIN     = 2'b10;

  localparam int         MAP_BITS  = 361;
  localparam logic [4:0] START_POS = 5'd1;
  localparam logic [4:0] MIN_NUM   = 5'd5;
  localparam logic [9:0] STEP_MAX  = 10'd1023;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Row-major bitmap index, deliberately kept at 9 bits.
  function automatic logic [8:0] map_index(input logic [4:0] tx,
                                           input logic [4:0] ty,
                                           input logic [4:0] n);
    return 9'(ty) * 9'(n) + 9'(tx);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one synchronous button level.
// The armed flop suppresses a press for a button held through reset.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic hist_q, hist_d;
  logic armed_q, armed_d;

  always_comb begin
    hist_d  = din;
    armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      armed_q <= armed_d;
    end
  end

  assign rise = din & ~hist_q & armed_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: start/win sequencing, move checking against the wall bitmap.
// Optional MAZE_AUTO_REPEAT_EN adds auto-repeat of a held direction button.
//
// state        | meaning
// FSM_WELCOME  | waiting for a start press with a legal maze size
// FSM_IDLE     | playing, waiting for a direction press
// FSM_CHECK    | evaluating the latched target block
// FSM_WIN      | player reached (num-2,num-2); waiting for start
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter logic [24:0] REPEAT_CYCLES = 25'd12_500_000,
  parameter logic [4:0]  MAX_NUM       = 5'd19
) (
  input  logic                vga_clk,
  input  logic                rst_sys_n,
  input  logic                btn_start,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic [4:0]          num,
  input  logic [MAP_BITS-1:0] map,
  output logic [1:0]          state,
  output logic [4:0]          x_index,
  output logic [4:0]          y_index,
  output logic [9:0]          step_cnt
);

  localparam logic [1:0] FSM_WELCOME = 2'b00;
  localparam logic [1:0] FSM_IDLE    = 2'b01;
  localparam logic [1:0] FSM_WIN     = 2'b10;
  localparam logic [1:0] FSM_CHECK   = 2'b11;

  logic [1:0] fsm_q, fsm_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic [4:0] tx_q, tx_d, ty_q, ty_d;
  logic [9:0] step_q, step_d;

  logic p_start, p_up, p_down, p_left, p_right;
  logic [3:0] rpt_press;
  logic [3:0] dir_press;
  logic       dir_valid;
  dir_e       dir_sel;
  logic [8:0] idx;
  logic       move_ok;
  logic [4:0] nx, ny;

  btn_edge u_edge_start (.clk(vga_clk), .rst_n(rst_sys_n), .din(btn_start), .rise(p_start));
  btn_edge u_edge_up    (.clk(vga_clk), .rst_n(rst_sys_n), .din(btn_up),    .rise(p_up));
  btn_edge u_edge_down  (.clk(vga_clk), .rst_n(rst_sys_n), .din(btn_down),  .rise(p_down));
  btn_edge u_edge_left  (.clk(vga_clk), .rst_n(rst_sys_n), .din(btn_left),  .rise(p_left));
  btn_edge u_edge_right (.clk(vga_clk), .rst_n(rst_sys_n), .din(btn_right), .rise(p_right));

`ifdef MAZE_AUTO_REPEAT_EN
  // held_*: 0 none, 1 up, 2 down, 3 left, 4 right (winning-priority level)
  logic [2:0]  held_now, held_q, held_d;
  logic [3:0]  held_1h;
  logic        held_edge;
  logic        rpt_on_q, rpt_on_d;
  logic [24:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_fire;

  always_comb begin
    held_now = 3'd0;
    held_1h  = 4'b0000;
    if (btn_up) begin
      held_now = 3'd1; held_1h = 4'b1000;
    end else if (btn_down) begin
      held_now = 3'd2; held_1h = 4'b0100;
    end else if (btn_left) begin
      held_now = 3'd3; held_1h = 4'b0010;
    end else if (btn_right) begin
      held_now = 3'd4; held_1h = 4'b0001;
    end
    held_edge = |(held_1h & {p_up, p_down, p_left, p_right});

    held_d    = held_now;
    rpt_on_d  = rpt_on_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (fsm_q == FSM_WELCOME || fsm_q == FSM_WIN || held_now == 3'd0) begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end else if (held_edge) begin
      rpt_on_d  = 1'b1;
      rpt_cnt_d = REPEAT_CYCLES - 25'd1;
    end else if (held_now != held_q) begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end else if (rpt_on_q) begin
      if (rpt_cnt_q == '0) begin
        rpt_fire  = (fsm_q == FSM_IDLE);
        rpt_cnt_d = REPEAT_CYCLES - 25'd1;
      end else begin
        rpt_cnt_d = rpt_cnt_q - 25'd1;
      end
    end
    rpt_press = rpt_fire ? held_1h : 4'b0000;
  end

  always_ff @(posedge vga_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      held_q    <= 3'd0;
      rpt_on_q  <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      held_q    <= held_d;
      rpt_on_q  <= rpt_on_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_press = 4'b0000;
`endif

  always_comb begin
    dir_press = {p_up, p_down, p_left, p_right} | rpt_press;
    dir_valid = |dir_press;
    if (dir_press[3])      dir_sel = DIR_UP;
    else if (dir_press[2]) dir_sel = DIR_DOWN;
    else if (dir_press[1]) dir_sel = DIR_LEFT;
    else                   dir_sel = DIR_RIGHT;
  end

  // A coordinate that wrapped below zero shows up as > num-1 and is rejected.
  always_comb begin
    idx     = map_index(tx_q, ty_q, num);
    move_ok = (tx_q <= num - 5'd1) && (ty_q <= num - 5'd1) &&
              (idx < 9'(MAP_BITS)) && !map[idx];
  end

  always_comb begin
    fsm_d  = fsm_q;
    x_d    = x_q;
    y_d    = y_q;
    tx_d   = tx_q;
    ty_d   = ty_q;
    step_d = step_q;
    nx     = x_q;
    ny     = y_q;
    case (fsm_q)
      FSM_WELCOME: begin
        if (p_start && num >= MIN_NUM && num <= MAX_NUM) begin
          fsm_d  = FSM_IDLE;
          x_d    = START_POS;
          y_d    = START_POS;
          step_d = '0;
        end
      end
      FSM_IDLE: begin
        if (dir_valid) begin
          fsm_d = FSM_CHECK;
          tx_d  = x_q;
          ty_d  = y_q;
          case (dir_sel)
            DIR_UP:   ty_d = y_q - 5'd1;
            DIR_DOWN: ty_d = y_q + 5'd1;
            DIR_LEFT: tx_d = x_q - 5'd1;
            default:  tx_d = x_q + 5'd1;
          endcase
        end
      end
      FSM_CHECK: begin
        if (move_ok) begin
          nx = tx_q;
          ny = ty_q;
          if (step_q != STEP_MAX) step_d = step_q + 10'd1;
        end
        x_d   = nx;
        y_d   = ny;
        fsm_d = (nx == num - 5'd2 && ny == num - 5'd2) ? FSM_WIN : FSM_IDLE;
      end
      FSM_WIN: begin
        if (p_start) fsm_d = FSM_WELCOME;
      end
      default: fsm_d = FSM_WELCOME;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      fsm_q  <= FSM_WELCOME;
      x_q    <= '0;
      y_q    <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
      step_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    case (fsm_q)
      FSM_IDLE, FSM_CHECK: state = ST_PLAY;
      FSM_WIN:             state = ST_WIN;
      default:             state = ST_WELCOME;
    endcase
  end

  assign x_index  = x_q;
  assign y_index  = y_q;
  assign step_cnt = step_q;

endmodule
